// File: rtl/seq_det_pkg.sv
// Shared types and constants for the stream controller and its serial 1011 detector.
package seq_det_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ctrl_state_e;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_state_e;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_1011_fsm.sv
// Mealy detector for the serial pattern 1011 (overlap allowed); advances only when en=1.
module pattern_1011_fsm
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  input  logic x,
  output logic hit
);
  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (en) begin
      case (state_q)
        S0: state_d = (x == PATTERN[3]) ? S1 : S0;
        S1: state_d = (x == PATTERN[2]) ? S2 : S1;
        S2: state_d = (x == PATTERN[1]) ? S3 : S0;
        S3: begin
          // A completing 1 can also open the next occurrence.
          state_d = (x == PATTERN[0]) ? S1 : S2;
          hit     = (x == PATTERN[0]);
        end
        default: state_d = S0;
      endcase
    end
  end

  // sync_clr acts after this cycle's bit has been evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         state_q <= S0;
    else if (sync_clr) state_q <= S0;
    else               state_q <= state_d;
  end
endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit stream controller feeding the 1011 detector, with a saturating
// match counter and a sticky threshold interrupt.
module seq_det_stream_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  cfg_thresh,
  input  logic              clr,
  output logic              bit_valid,
  output logic              bit_out,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq,
  output logic              busy
);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_e       state_q;
  logic [WORD_W-1:0] sh_q;
  logic [IDX_W-1:0]  idx_q;
  logic              last_q;
  logic              match_q, irq_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit, last_bit, accept;

  assign last_bit  = (state_q == SHIFT) && (idx_q == '0);
  assign in_ready  = (state_q == IDLE) || last_bit;
  assign accept    = in_valid && in_ready;
  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid && sh_q[WORD_W-1];
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      // Covers both the IDLE load and the bubble-free reload on the last bit.
      state_q <= SHIFT;
      sh_q    <= in_data;
      idx_q   <= IDX_TOP;
      last_q  <= in_last;
    end else if (state_q == SHIFT) begin
      sh_q  <= {sh_q[WORD_W-2:0], 1'b0};
      idx_q <= idx_q - IDX_W'(1);
      if (last_bit) state_q <= IDLE;
    end
  end

  pattern_1011_fsm u_det (
    .clk      (clk),
    .reset    (reset),
    .en       (bit_valid),
    .sync_clr (last_bit && last_q),
    .x        (bit_out),
    .hit      (hit)
  );

  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      match_q <= hit;
      if (clr) begin
        cnt_q <= '0;
        irq_q <= 1'b0;
      end else if (hit) begin
        cnt_q <= cnt_d;
        // Only the crossing sets irq; lowering the threshold later does not.
        if (cnt_d == cfg_thresh && cfg_thresh != '0) irq_q <= 1'b1;
      end
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Scoreboard bench: accepted words push expected bits/hits, a negedge monitor
// pops them and predicts match/count/irq for the following cycle.
module tb_seq_det_stream_ctrl;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 8;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, clr = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic [CNT_W-1:0]  cfg_thresh = '0;
  logic in_ready, bit_valid, bit_out, match, irq, busy;
  logic [CNT_W-1:0] match_count;

  int n_tests = 0, n_fail = 0;
  bit exp_bit_q[$];
  bit exp_hit_q[$];
  logic [3:0] hist = '0;
  logic p_match = 1'b0, m_irq = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;
  int run = 0, max_run = 0, rdy_in_run = 0;

  seq_det_stream_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .cfg_thresh(cfg_thresh), .clr(clr),
    .bit_valid(bit_valid), .bit_out(bit_out), .match(match),
    .match_count(match_count), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic hit;
    logic [CNT_W-1:0] inc;
    if (reset) begin
      exp_bit_q.delete();
      exp_hit_q.delete();
      p_match = 1'b0; m_cnt = '0; m_irq = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_bit_out", bit_out, 0);
      chk("rst_match", match, 0);
      chk("rst_count", match_count, 0);
      chk("rst_irq", irq, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("match", match, p_match);
      chk("count", match_count, m_cnt);
      chk("irq", irq, m_irq);
      hit = 1'b0;
      if (bit_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (in_ready) rdy_in_run++;
        if (exp_bit_q.size() == 0) chk("unexpected_bit", 1, 0);
        else begin
          chk("bit_out", bit_out, exp_bit_q.pop_front());
          hit = exp_hit_q.pop_front();
        end
      end else run = 0;
      p_match = hit;
      if (clr) begin
        m_cnt = '0; m_irq = 1'b0;
      end else if (hit) begin
        inc = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
        if (inc == cfg_thresh && cfg_thresh != 0) m_irq = 1'b1;
        m_cnt = inc;
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_word(input logic [WORD_W-1:0] d, input bit l);
    int g = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      hist = {hist[2:0], d[i]};
      exp_bit_q.push_back(d[i]);
      exp_hit_q.push_back(hist == 4'b1011);
    end
    if (l) hist = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_bit_q.size() != 0 || busy) && g < 2000) begin @(negedge clk); g++; end
    if (g >= 2000) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; hist = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("cnt_reset", match_count, 0);

    send_word(8'hB0, 1'b1); drain();
    chk("cnt_b0", match_count, 1);
    send_word(8'hB6, 1'b1); drain();
    chk("cnt_b6_overlap", match_count, 3);
    send_word(8'h05, 1'b0); send_word(8'h80, 1'b1); drain();
    chk("cnt_span", match_count, 4);
    send_word(8'h05, 1'b1); send_word(8'h80, 1'b1); drain();
    chk("cnt_no_span", match_count, 4);

    do_reset();
    cfg_thresh = 8'd3;
    send_word(8'hB0, 1'b1); drain();
    send_word(8'hB0, 1'b1); drain();
    chk("irq_below", irq, 0);
    send_word(8'hB0, 1'b1); drain();
    chk("irq_at_thresh", irq, 1);
    chk("cnt_at_thresh", match_count, 3);
    send_word(8'hB0, 1'b1); drain();
    chk("irq_sticky", irq, 1);
    pulse_clr(); #1;
    chk("cnt_clr", match_count, 0);
    chk("irq_clr", irq, 0);
    // Hit is evaluated in the 4th bit cycle; clr lands on that same edge.
    send_word(8'hB0, 1'b1);
    repeat (3) @(posedge clk);
    #1 pulse_clr();
    drain();
    chk("cnt_clr_vs_match", match_count, 0);

    cfg_thresh = 8'd0;
    send_word(8'hB6, 1'b1); drain();
    cfg_thresh = 8'd1;
    send_word(8'hB0, 1'b1); drain();
    chk("cnt_thresh_lowered", match_count, 3);
    chk("irq_no_retro", irq, 0);

    max_run = 0; rdy_in_run = 0;
    send_word(8'hB0, 1'b1); send_word(8'hB0, 1'b1); drain();
    chk("b2b_run", max_run, 16);
    chk("b2b_ready_cycles", rdy_in_run, 2);
    chk("cnt_b2b", match_count, 5);

    send_word(8'hB0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; hist = '0;
    @(negedge clk);
    chk("midrst_bit_valid", bit_valid, 0);
    chk("midrst_count", match_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("postrst_no_match_cnt", match_count, 0);
    send_word(8'hB0, 1'b1); drain();
    chk("postrst_one_match", match_count, 1);

    do_reset();
    cfg_thresh = 8'd0;
    for (int i = 0; i < 130; i++) send_word(8'hB6, 1'b1);
    drain();
    chk("cnt_saturate", match_count, 255);
    chk("irq_disabled", irq, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
